// File: rtl/poly_mod_stream.sv
// Streaming mod-q coefficient reducer, EXTRA_BITS+1 cycle latency, 1 beat/cycle, LANES coeffs per beat.
// Backpressure: ready_o = !valid_o || ready_i; when low the whole pipeline freezes.
module poly_mod_stream #(
    parameter int BIT_WIDTH  = 32,
    parameter int EXTRA_BITS = 4,
    parameter int DEGREE_N   = 1024,
    parameter int LANES      = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [BIT_WIDTH-1:0]                   q,
    input  logic                                   centered,
    input  logic [LANES*(BIT_WIDTH+EXTRA_BITS)-1:0] coeff_i,
    input  logic                                   valid_i,
    output logic                                   ready_o,
    output logic [LANES*BIT_WIDTH-1:0]             coeff_o,
    output logic                                   valid_o,
    input  logic                                   ready_i,
    output logic                                   last_o,
    output logic [$clog2(DEGREE_N)-1:0]            idx_o,
    output logic                                   range_err_o,
    output logic [15:0]                            poly_cnt_o
);

    localparam int XW = BIT_WIDTH + EXTRA_BITS;
    localparam int IW = $clog2(DEGREE_N);
    localparam int NS = EXTRA_BITS + 1;
    localparam logic [IW-1:0] IDX_STEP = IW'(LANES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEGREE_N - LANES);

    function automatic logic [LANES*XW-1:0] sub_stage(input logic [LANES*XW-1:0] x,
                                                      input logic [BIT_WIDTH-1:0] m,
                                                      input int k);
        logic [XW-1:0] lane;
        logic [XW-1:0] qs;
        sub_stage = x;
        qs = {{EXTRA_BITS{1'b0}}, m} << k;
        for (int l = 0; l < LANES; l++) begin
            lane = x[l*XW +: XW];
            if (lane >= qs) sub_stage[l*XW +: XW] = lane - qs;
        end
    endfunction

    function automatic logic [LANES*BIT_WIDTH-1:0] center(input logic [LANES*XW-1:0] x,
                                                         input logic [BIT_WIDTH-1:0] m,
                                                         input logic c);
        logic [BIT_WIDTH-1:0] r;
        center = '0;
        for (int l = 0; l < LANES; l++) begin
            r = x[l*XW +: BIT_WIDTH];
            if (c && (r > (m >> 1))) r = r - m;
            center[l*BIT_WIDTH +: BIT_WIDTH] = r;
        end
    endfunction

    function automatic logic over_range(input logic [LANES*XW-1:0] x,
                                        input logic [BIT_WIDTH-1:0] m);
        over_range = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if (x[l*XW +: XW] >= {m, {EXTRA_BITS{1'b0}}}) over_range = 1'b1;
        end
    endfunction

    // Stage 0 holds the raw accepted beat; stage j holds the result after subtracting q<<(EXTRA_BITS-j).
    logic [LANES*XW-1:0]  dat_q [NS];
    logic [LANES*XW-1:0]  dat_d [NS];
    logic [BIT_WIDTH-1:0] sq_q  [NS];
    logic [BIT_WIDTH-1:0] sq_d  [NS];
    logic                 cen_q [NS];
    logic                 cen_d [NS];
    logic                 vld_q [NS];
    logic                 vld_d [NS];
    logic                 lst_q [NS];
    logic                 lst_d [NS];
    logic [IW-1:0]        idx_q [NS];
    logic [IW-1:0]        idx_d [NS];

    logic [BIT_WIDTH-1:0]       poly_q_q, poly_q_d;
    logic                       pcen_q, pcen_d;
    logic [IW-1:0]              cnt_q, cnt_d;
    logic [LANES*BIT_WIDTH-1:0] out_dat_q, out_dat_d;
    logic                       out_vld_q, out_vld_d;
    logic                       out_lst_q, out_lst_d;
    logic [IW-1:0]              out_idx_q, out_idx_d;
    logic                       err_q, err_d;
    logic [15:0]                pcnt_q, pcnt_d;

    logic                 adv;
    logic                 accept;
    logic                 first;
    logic                 last_in;
    logic [BIT_WIDTH-1:0] q_eff;
    logic                 cen_eff;

    always_comb begin
        adv     = !out_vld_q || ready_i;
        accept  = valid_i && adv;
        first   = (cnt_q == '0);
        last_in = (cnt_q == IDX_LAST);
        q_eff   = first ? q : poly_q_q;
        cen_eff = first ? centered : pcen_q;

        for (int j = 0; j < NS; j++) begin
            dat_d[j] = dat_q[j];
            sq_d[j]  = sq_q[j];
            cen_d[j] = cen_q[j];
            vld_d[j] = vld_q[j];
            lst_d[j] = lst_q[j];
            idx_d[j] = idx_q[j];
        end
        poly_q_d  = poly_q_q;
        pcen_d    = pcen_q;
        cnt_d     = cnt_q;
        out_dat_d = out_dat_q;
        out_vld_d = out_vld_q;
        out_lst_d = out_lst_q;
        out_idx_d = out_idx_q;
        err_d     = err_q;
        pcnt_d    = pcnt_q;

        if (adv) begin
            dat_d[0] = coeff_i;
            sq_d[0]  = q_eff;
            cen_d[0] = cen_eff;
            vld_d[0] = valid_i;
            lst_d[0] = last_in;
            idx_d[0] = cnt_q;
            for (int j = 1; j < NS; j++) begin
                dat_d[j] = sub_stage(dat_q[j-1], sq_q[j-1], EXTRA_BITS - j);
                sq_d[j]  = sq_q[j-1];
                cen_d[j] = cen_q[j-1];
                vld_d[j] = vld_q[j-1];
                lst_d[j] = lst_q[j-1];
                idx_d[j] = idx_q[j-1];
            end
            out_dat_d = center(dat_q[NS-1], sq_q[NS-1], cen_q[NS-1]);
            out_vld_d = vld_q[NS-1];
            out_lst_d = lst_q[NS-1];
            out_idx_d = idx_q[NS-1];
        end

        if (accept) begin
            cnt_d = last_in ? '0 : cnt_q + IDX_STEP;
            if (first) begin
                poly_q_d = q;
                pcen_d   = centered;
            end
            if (over_range(coeff_i, q_eff) || (first && (q < BIT_WIDTH'(2)))) err_d = 1'b1;
        end

        if (out_vld_q && ready_i && out_lst_q) pcnt_d = pcnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NS; j++) begin
                dat_q[j] <= '0;
                sq_q[j]  <= '0;
                cen_q[j] <= 1'b0;
                vld_q[j] <= 1'b0;
                lst_q[j] <= 1'b0;
                idx_q[j] <= '0;
            end
            poly_q_q  <= '0;
            pcen_q    <= 1'b0;
            cnt_q     <= '0;
            out_dat_q <= '0;
            out_vld_q <= 1'b0;
            out_lst_q <= 1'b0;
            out_idx_q <= '0;
            err_q     <= 1'b0;
            pcnt_q    <= '0;
        end else begin
            for (int j = 0; j < NS; j++) begin
                dat_q[j] <= dat_d[j];
                sq_q[j]  <= sq_d[j];
                cen_q[j] <= cen_d[j];
                vld_q[j] <= vld_d[j];
                lst_q[j] <= lst_d[j];
                idx_q[j] <= idx_d[j];
            end
            poly_q_q  <= poly_q_d;
            pcen_q    <= pcen_d;
            cnt_q     <= cnt_d;
            out_dat_q <= out_dat_d;
            out_vld_q <= out_vld_d;
            out_lst_q <= out_lst_d;
            out_idx_q <= out_idx_d;
            err_q     <= err_d;
            pcnt_q    <= pcnt_d;
        end
    end

    assign ready_o     = adv;
    assign coeff_o     = out_dat_q;
    assign valid_o     = out_vld_q;
    assign last_o      = out_lst_q;
    assign idx_o       = out_idx_q;
    assign range_err_o = err_q;
    assign poly_cnt_o  = pcnt_q;

endmodule

// File: tb/tb_poly_mod_stream.sv
// Directed bench for poly_mod_stream: 2-lane, 16-bit, 8-coefficient polynomials,
// table-driven per-polynomial vectors plus hand sequences for latency, stall, q change and reset.
module tb_poly_mod_stream;

    logic        clk;
    logic        rst;
    logic [15:0] q;
    logic        centered;
    logic [39:0] coeff_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] coeff_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic [2:0]  idx_o;
    logic        range_err_o;
    logic [15:0] poly_cnt_o;

    poly_mod_stream #(
        .BIT_WIDTH (16),
        .EXTRA_BITS(4),
        .DEGREE_N  (8),
        .LANES     (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .q          (q),
        .centered   (centered),
        .coeff_i    (coeff_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .coeff_o    (coeff_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .last_o     (last_o),
        .idx_o      (idx_o),
        .range_err_o(range_err_o),
        .poly_cnt_o (poly_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [19:0] x0;
        logic [19:0] x1;
        logic [15:0] qv;
        logic        cv;
        logic [15:0] e0;
        logic [15:0] e1;
    } vec_t;

    typedef struct {
        logic [31:0] dat;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    vec_t tbl [8];
    exp_t exp_q [$];
    exp_t mon_e;
    int   exp_idx;
    int   n_cmp;
    int   n_fail;

    logic [31:0] snap_dat;
    logic [2:0]  snap_idx;
    logic        snap_last;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got %h required %h", name, got, req);
        end
    endtask

    task automatic send(input logic [19:0] x0, input logic [19:0] x1, input logic [15:0] qv,
                        input logic cv, input logic [15:0] e0, input logic [15:0] e1);
        exp_t e;
        int   n;
        coeff_i  = {x1, x0};
        q        = qv;
        centered = cv;
        valid_i  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout ready_o=%0b required 1", ready_o);
            valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        e.dat  = {e1, e0};
        e.idx  = 3'(exp_idx);
        e.last = (exp_idx == 6);
        exp_q.push_back(e);
        exp_idx = (exp_idx == 6) ? 0 : exp_idx + 2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output transfer must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat coeff_o=%h idx_o=%0d", coeff_o, idx_o);
            end else begin
                mon_e = exp_q.pop_front();
                if (coeff_o !== mon_e.dat || idx_o !== mon_e.idx || last_o !== mon_e.last) begin
                    n_fail++;
                    $display("FAIL beat got dat=%h idx=%0d last=%0b required dat=%h idx=%0d last=%0b",
                             coeff_o, idx_o, last_o, mon_e.dat, mon_e.idx, mon_e.last);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        exp_idx  = 0;
        rst      = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        q        = 16'h1337;
        centered = 1'b0;
        coeff_i  = '0;

        tbl[0] = '{20'h00012, 20'h00012, 16'h1337, 1'b0, 16'h0012, 16'h0012};
        tbl[1] = '{20'h00010, 20'h00010, 16'h1337, 1'b0, 16'h0010, 16'h0010};
        tbl[2] = '{20'h039AA, 20'h01337, 16'h1337, 1'b0, 16'h0005, 16'h0000};
        tbl[3] = '{20'd4000,  20'd2459,  16'h1337, 1'b1, 16'hFC69, 16'h099B};
        tbl[4] = '{20'd78703, 20'd2460,  16'h1337, 1'b1, 16'hFFFF, 16'hF665};
        tbl[5] = '{20'd78703, 20'd0,     16'h1337, 1'b0, 16'h1336, 16'h0000};
        tbl[6] = '{20'd1000,  20'd257,   16'h0101, 1'b0, 16'h00E5, 16'h0000};
        tbl[7] = '{20'h00012, 20'h00010, 16'h1337, 1'b0, 16'h0012, 16'h0010};

        #1;
        chk("rst_valid_o",   64'(valid_o),     64'd0);
        chk("rst_coeff_o",   64'(coeff_o),     64'd0);
        chk("rst_idx_last",  64'({idx_o, last_o}), 64'd0);
        chk("rst_poly_cnt",  64'(poly_cnt_o),  64'd0);
        chk("rst_range_err", 64'(range_err_o), 64'd0);
        chk("rst_ready_o",   64'(ready_o),     64'd1);
        #20;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            repeat (4) send(tbl[i].x0, tbl[i].x1, tbl[i].qv, tbl[i].cv, tbl[i].e0, tbl[i].e1);
        end
        drain();
        chk("table_poly_cnt",  64'(poly_cnt_o),  64'd8);
        chk("table_range_err", 64'(range_err_o), 64'd0);

        // Latency: lone beat into an empty pipeline.
        send(20'h039AA, 20'h01337, 16'h1337, 1'b0, 16'h0005, 16'h0000);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 4) chk("lat_before", 64'(valid_o), 64'd0);
            if (c == 5) chk("lat_at",     64'(valid_o), 64'd1);
        end
        repeat (3) send(20'h00012, 20'h00012, 16'h1337, 1'b0, 16'h0012, 16'h0012);
        drain();
        chk("lat_poly_cnt", 64'(poly_cnt_o), 64'd9);

        // Range error: 16q on lane 0, then a clean polynomial.
        chk("err_before", 64'(range_err_o), 64'd0);
        send(20'h13370, 20'h00012, 16'h1337, 1'b0, 16'h1337, 16'h0012);
        chk("err_set", 64'(range_err_o), 64'd1);
        repeat (3) send(20'h00012, 20'h00012, 16'h1337, 1'b0, 16'h0012, 16'h0012);
        repeat (4) send(20'h039AA, 20'h01337, 16'h1337, 1'b0, 16'h0005, 16'h0000);
        drain();
        chk("err_sticky", 64'(range_err_o), 64'd1);

        // q changes on beat 2; it only takes effect on the next polynomial.
        send(20'd1000, 20'd1000, 16'h1337, 1'b0, 16'h03E8, 16'h03E8);
        repeat (3) send(20'd1000, 20'd1000, 16'h0101, 1'b0, 16'h03E8, 16'h03E8);
        repeat (4) send(20'd1000, 20'd1000, 16'h0101, 1'b0, 16'h00E5, 16'h00E5);
        drain();
        chk("qchg_poly_cnt", 64'(poly_cnt_o), 64'd13);

        // Backpressure: downstream stalls for 10 cycles once the first beat is presented.
        ready_i = 1'b0;
        fork
            begin
                repeat (4) send(20'h00012, 20'h00010, 16'h1337, 1'b0, 16'h0012, 16'h0010);
                repeat (4) send(20'h039AA, 20'h00012, 16'h1337, 1'b0, 16'h0005, 16'h0012);
            end
            begin
                int n;
                n = 0;
                while (!valid_o && n < 50) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("stall_valid_seen", 64'(valid_o), 64'd1);
                snap_dat  = coeff_o;
                snap_idx  = idx_o;
                snap_last = last_o;
                for (int c = 0; c < 10; c++) begin
                    chk("stall_hold", 64'({ready_o, valid_o, last_o, idx_o, coeff_o}),
                        64'({1'b0, 1'b1, snap_last, snap_idx, snap_dat}));
                    @(posedge clk);
                    #1;
                end
                ready_i = 1'b1;
            end
        join
        drain();
        chk("stall_poly_cnt", 64'(poly_cnt_o), 64'd15);

        // Reset with three beats in flight.
        repeat (3) send(20'h00012, 20'h00012, 16'h1337, 1'b0, 16'h0012, 16'h0012);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid_o",   64'(valid_o),     64'd0);
        chk("mid_rst_poly_cnt",  64'(poly_cnt_o),  64'd0);
        chk("mid_rst_range_err", 64'(range_err_o), 64'd0);
        exp_q.delete();
        exp_idx = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (4) send(20'h00010, 20'h00010, 16'h1337, 1'b0, 16'h0010, 16'h0010);
        drain();
        chk("post_rst_poly_cnt", 64'(poly_cnt_o), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/poly_mod_stream.md
Name: poly_mod_stream

Overview:
- Parametrised successor to the single-lane poly_mod coefficient reducer.
- Reduces a stream of polynomial coefficients modulo q using a fixed-latency pipeline of conditional subtractions.
- Generalised in lane count, input headroom and output mode (standard or centered), with ready/valid backpressure and polynomial framing.
- Sits between the NTT/multiply datapath, which produces wide unreduced coefficients, and the ciphertext buffers.

Parameters:
BIT_WIDTH, 32, modulus and output coefficient width
EXTRA_BITS, 4, input headroom bits; one pipeline subtract stage per bit
DEGREE_N, 1024, coefficients per polynomial; must be divisible by LANES
LANES, 1, coefficients carried per beat

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
q  in  BIT_WIDTH  modulus; sampled on the first beat of each polynomial
centered  in  1  output mode; sampled with q
coeff_i  in  LANES*(BIT_WIDTH+EXTRA_BITS)  input coefficients; lane 0 in the LSBs
valid_i  in  1  input beat valid
ready_o  out  1  block can accept a beat
coeff_o  out  LANES*BIT_WIDTH  reduced coefficients; lane 0 in the LSBs
valid_o  out  1  output beat valid
ready_i  in  1  downstream accepts the beat
last_o  out  1  final beat of a polynomial
idx_o  out  $clog2(DEGREE_N)  coefficient index of lane 0 of the output beat
range_err_o  out  1  sticky error flag
poly_cnt_o  out  16  completed polynomials, wraps at 2^16

Behaviour:
- Reset: all stage valids, valid_o, last_o, idx_o, poly_cnt_o, range_err_o and coeff_o are 0. The input beat counter is 0. Effect is immediate (async). In-flight beats are discarded. After release, the next accepted beat is index 0 of a new polynomial.
- Handshake:
  - Accept when valid_i && ready_o.
  - Transfer out when valid_o && ready_i.
  - ready_o = !valid_o || ready_i. This combinational path is allowed.
  - When ready_o is low, the whole pipeline holds; coeff_o, valid_o, last_o and idx_o stay stable.
  - Bubbles advance normally.
- Latency: LAT = EXTRA_BITS+1 cycles from the accepting edge to valid_o with no stall; throughput is 1 beat/cycle.
- Pipeline:
  - Stage k (k = EXTRA_BITS-1 down to 0) per lane: if x >= (q<<k) then x -= (q<<k).
  - A final register applies centering and truncates to BIT_WIDTH.
  - Every stage carries its own q, centered, idx and last. A q change mid-polynomial therefore has no effect on beats already accepted or on later beats of the same polynomial.
- Framing:
  - The input beat counter increments by LANES per accepted beat.
  - At DEGREE_N-LANES the beat is tagged last and the counter wraps to 0.
  - q and centered are latched when an accepted beat has counter 0.
- Centered mode: with result r in [0,q), if r > (q>>1) the output is r-q in BIT_WIDTH two's complement; otherwise r.
- range_err_o is set, and held until reset, when an accepted beat has any lane with x >= (q<<EXTRA_BITS), or when q < 2 on a first beat. The data is still processed by the same stage rule (deterministic, no saturation).
- poly_cnt_o increments on each output transfer with last_o=1.
- Simultaneous accept and output transfer in one cycle is normal streaming; no special case.

Test Plan:
Common config: BIT_WIDTH=16, EXTRA_BITS=4, DEGREE_N=8, LANES=2, q=0x1337, centered=0, ready_i=1 unless stated.
1. Two polynomials, all lanes 0x12 then all 0x10 -> outputs 0x12 then 0x10. idx_o 0,2,4,6 per polynomial; last_o on the 4th and 8th beat; poly_cnt_o=2; range_err_o=0.
2. Single beat, lanes {0x039AA, 0x01337} -> {0x0005, 0x0000}. valid_o rises exactly 5 cycles after the accepting edge.
3. centered=1, lanes {4000, 2459} -> {0xFC69, 0x099B}. Lane 1 equals q>>1, so it is not shifted.
4. Lane x=0x13370 (16q) -> range_err_o=1 from the next cycle and stays set. Lane output is 0x1337. A subsequent valid polynomial still reduces correctly.
5. Backpressure: 4 beats sent, ready_i=0 for 10 cycles from the first valid_o -> ready_o falls while valid_o=1; outputs are held stable. After release all 4 beats emerge in order with no loss or duplication.
6. q changed to 0x0101 during beat 2 of a polynomial -> beats 2-4 are still reduced mod 0x1337; the next polynomial uses 0x0101. Separately, rst pulsed with 3 beats in flight -> valid_o=0 immediately and poly_cnt_o=0; the next accepted beat emerges with idx_o=0.
